// File: rtl/stc_pe_mac_if.sv
// Operand/result bundle for one sparse tensor-core processing element.
// The datapath side drives the operands; the PE returns its registered row.
interface stc_pe_mac_if #(
  parameter int N       = 8,
  parameter int DW_DATA = 8
);
  logic [DW_DATA-1:0]   A_element;
  logic [N*DW_DATA-1:0] B_row;
  logic [N*DW_DATA-1:0] C_row;
  logic                 load_en;
  logic                 acc_en;
  logic [N*DW_DATA-1:0] D_row;

  modport master (
    output A_element,
    output B_row,
    output C_row,
    output load_en,
    output acc_en,
    input  D_row
  );

  modport slave (
    input  A_element,
    input  B_row,
    input  C_row,
    input  load_en,
    input  acc_en,
    output D_row
  );
endinterface

// File: rtl/stc_pe_mac.sv
// Sparse tensor-core processing element: N-lane scalar-times-row multiply-add.
// A stationary B row is held in a register; every cycle each lane computes
// A * B[i] (truncated) plus either C[i] or its own previous result, modulo
// 2^DW_DATA. D_row comes straight from a register.
module stc_pe_mac #(
  parameter int N       = 8,
  parameter int DW_DATA = 8
) (
  input  logic         clk,
  input  logic         reset,
  stc_pe_mac_if.slave  bus
);

  logic [N*DW_DATA-1:0] r_b_reg;
  logic [N*DW_DATA-1:0] r_d_row;
  logic [N*DW_DATA-1:0] w_d_next;

  // Per-lane multiply-add; uses the pre-edge stationary row so a fresh load
  // only contributes from the following edge onward.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [DW_DATA-1:0] w_prod;
      logic [DW_DATA-1:0] w_addend;

      assign w_prod   = bus.A_element * r_b_reg[gi*DW_DATA +: DW_DATA];
      assign w_addend = bus.acc_en ? r_d_row[gi*DW_DATA +: DW_DATA]
                                   : bus.C_row[gi*DW_DATA +: DW_DATA];
      assign w_d_next[gi*DW_DATA +: DW_DATA] = w_addend + w_prod;
    end
  endgenerate

  // Stationary operand and result registers; both clear immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_b_reg <= '0;
      r_d_row <= '0;
    end else begin
      if (bus.load_en) begin
        r_b_reg <= bus.B_row;
      end
      r_d_row <= w_d_next;
    end
  end

  assign bus.D_row = r_d_row;

endmodule

// File: tb/tb_stc_pe_mac.sv
// Self-checking bench for stc_pe_mac: directed scenarios with literal
// expectations plus a randomized run checked against a lane-array model.
module tb_stc_pe_mac;
  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int MOD = 256;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  int   mb [N];
  int   md [N];

  stc_pe_mac_if #(.N(N), .DW_DATA(DW)) bus ();

  stc_pe_mac #(.N(N), .DW_DATA(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] model_d();
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = md[i][DW-1:0];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mb[i] = 0;
      md[i] = 0;
    end
  endtask

  // Advance one rising edge, update the model from the inputs seen at that
  // edge, then settle past the edge before anyone samples.
  task automatic do_edge();
    int nd [N];
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        nd[i] = bus.acc_en ? md[i] : int'(bus.C_row[i*DW +: DW]);
        nd[i] = (nd[i] + int'(bus.A_element) * mb[i]) % MOD;
      end
      for (int i = 0; i < N; i++) begin
        md[i] = nd[i];
        if (bus.load_en) mb[i] = int'(bus.B_row[i*DW +: DW]);
      end
    end else begin
      model_clear();
    end
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic [N*DW-1:0] b,
                       input logic [N*DW-1:0] c, input logic ld, input logic acc);
    bus.A_element = a;
    bus.B_row     = b;
    bus.C_row     = c;
    bus.load_en   = ld;
    bus.acc_en    = acc;
  endtask

  task automatic test_reset();
    logic [N*DW-1:0] exp;
    exp = '0;
    reset = 1'b0;
    #1;
    total++;
    if (bus.D_row !== exp) $display("FAIL reset_immediate D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    for (int k = 0; k < 6; k++) begin
      drive(DW'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom), 1'($urandom));
      do_edge();
      total++;
      if (bus.D_row !== exp) $display("FAIL reset_hold cyc%0d D_row=%h expected=%h", k, bus.D_row, exp);
      else passed++;
    end
    drive('0, '0, '0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      do_edge();
      total++;
      if (bus.D_row !== exp) $display("FAIL reset_release cyc%0d D_row=%h expected=%h", k, bus.D_row, exp);
      else passed++;
    end
    $display("test_reset done");
  endtask

  task automatic test_load_multiply();
    logic [N*DW-1:0] brow, bdecoy, exp;
    brow   = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    bdecoy = {8'd0, 8'd3, 8'd5, 8'd4, 8'd7, 8'd2, 8'd8, 8'd0};
    drive(8'd1, brow, '0, 1'b1, 1'b0);
    do_edge();
    exp = '0;
    total++;
    if (bus.D_row !== exp) $display("FAIL load_edge1 D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    drive(8'd2, bdecoy, '0, 1'b0, 1'b0);
    do_edge();
    exp = {8'd14, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4, 8'd2, 8'd0};
    total++;
    if (bus.D_row !== exp) $display("FAIL load_edge2 D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    $display("test_load_multiply done");
  endtask

  task automatic test_c_add();
    logic [N*DW-1:0] exp;
    drive(8'd3, '0, {N{8'd1}}, 1'b0, 1'b0);
    do_edge();
    exp = {8'd22, 8'd19, 8'd16, 8'd13, 8'd10, 8'd7, 8'd4, 8'd1};
    total++;
    if (bus.D_row !== exp) $display("FAIL c_add D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    $display("test_c_add done");
  endtask

  task automatic test_accumulate();
    logic [N*DW-1:0] exp;
    drive(8'd0, '0, '0, 1'b0, 1'b0);
    do_edge();
    exp = '0;
    total++;
    if (bus.D_row !== exp) $display("FAIL acc_zero D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    drive(8'd1, '0, {N{8'hAA}}, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      do_edge();
      for (int i = 0; i < N; i++) exp[i*DW +: DW] = DW'(i * k);
      total++;
      if (bus.D_row !== exp) $display("FAIL acc_step%0d D_row=%h expected=%h", k, bus.D_row, exp);
      else passed++;
    end
    exp = {8'd21, 8'd18, 8'd15, 8'd12, 8'd9, 8'd6, 8'd3, 8'd0};
    drive(8'd0, '0, {N{8'h55}}, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      do_edge();
      total++;
      if (bus.D_row !== exp) $display("FAIL acc_hold cyc%0d D_row=%h expected=%h", k, bus.D_row, exp);
      else passed++;
    end
    $display("test_accumulate done");
  endtask

  task automatic test_wrap();
    logic [N*DW-1:0] exp;
    drive(8'd0, {N{8'hFF}}, '0, 1'b1, 1'b0);
    do_edge();
    drive(8'd2, '0, '0, 1'b0, 1'b0);
    do_edge();
    exp = {N{8'hFE}};
    total++;
    if (bus.D_row !== exp) $display("FAIL wrap_prod D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    drive(8'd2, '0, {N{8'h03}}, 1'b0, 1'b0);
    do_edge();
    exp = {N{8'h01}};
    total++;
    if (bus.D_row !== exp) $display("FAIL wrap_sum D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    $display("test_wrap done");
  endtask

  task automatic test_async_reset();
    logic [N*DW-1:0] exp;
    drive(8'd0, {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, '0, 1'b1, 1'b0);
    do_edge();
    drive(8'd1, '0, '0, 1'b0, 1'b1);
    do_edge();
    do_edge();
    exp = {8'd14, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4, 8'd2, 8'd0};
    total++;
    if (bus.D_row !== exp) $display("FAIL async_pre D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    #2 reset = 1'b0;
    model_clear();
    #1;
    exp = '0;
    total++;
    if (bus.D_row !== exp) $display("FAIL async_d D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    total++;
    if (dut.r_b_reg !== exp) $display("FAIL async_b b_reg=%h expected=%h", dut.r_b_reg, exp);
    else passed++;
    #1 reset = 1'b1;
    drive(8'd1, '0, '0, 1'b0, 1'b0);
    do_edge();
    total++;
    if (bus.D_row !== exp) $display("FAIL async_after D_row=%h expected=%h", bus.D_row, exp);
    else passed++;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [N*DW-1:0] exp;
    int errs;
    errs = 0;
    for (int k = 0; k < 300; k++) begin
      drive(DW'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0), 1'($urandom));
      do_edge();
      exp = model_d();
      total++;
      if (bus.D_row !== exp) begin
        errs++;
        $display("FAIL random cyc%0d D_row=%h expected=%h", k, bus.D_row, exp);
      end else passed++;
    end
    $display("test_random done errors=%0d", errs);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    model_clear();
    drive('0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    test_reset();
    test_load_multiply();
    test_c_add();
    test_accumulate();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stc_pe_mac.md
Name: stc_pe_mac

Overview:
- Processing element for the unstructured sparse tensor core. Performs an N-lane scalar-times-row multiply-add.
- Holds a stationary B row in a register. Each cycle it multiplies the broadcast A_element by every lane of that row and adds either the incoming C_row or its own running result.
- Instantiated in arrays by the sparse tensor-core datapath. D_row feeds the next stage or the output buffer.

Parameters:
- N, 8, number of lanes per row.
- DW_DATA, 8, bit width of each element (A, B, C and D lanes).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- A_element  input  DW_DATA  scalar broadcast to all lanes.
- B_row  input  N*DW_DATA  row to be latched as the stationary operand.
- C_row  input  N*DW_DATA  addend row.
- load_en  input  1  latch B_row into the stationary B register.
- acc_en  input  1  1 = accumulate into D_row; 0 = add C_row.
- D_row  output  N*DW_DATA  registered result row.

Behaviour:
- Lane packing: lane i occupies bits [i*DW_DATA+DW_DATA-1 : i*DW_DATA] of B_row, C_row, D_row and of the internal b_reg. Lane 0 is the LSBs.
- Arithmetic is unsigned. The product A_element*b_reg[i] is truncated to its DW_DATA LSBs. Sums wrap modulo 2^DW_DATA. There is no saturation and no overflow flag.
- State: b_reg (N*DW_DATA) and the D_row register (N*DW_DATA).
- Reset (reset=0, asynchronous): b_reg=0 and D_row=0 immediately, independent of clk. Both hold 0 while reset is low. Operation resumes on the first rising edge after reset goes high.
- Each rising edge with reset=1:
  - if load_en=1: b_reg <= B_row; otherwise b_reg holds.
  - if acc_en=0: D[i] <= C[i] + A_element*b_reg[i].
  - if acc_en=1: D[i] <= D[i] + A_element*b_reg[i]. C_row is ignored.
- The D update always uses the pre-edge value of b_reg. A newly loaded B row therefore first contributes to D on the edge after the load edge.
- load_en and acc_en asserted together: both take effect. The load writes b_reg and the accumulate uses the old b_reg.
- Latency: 1 cycle from A_element/C_row to D_row. 2 edges from B_row load to the first D_row reflecting it.
- D_row is updated every cycle; there is no hold/stall input. To freeze D, hold A_element=0 with acc_en=1.
- D_row is driven directly from the register, with no combinational path from inputs to output.
- Reset asserted mid-operation clears b_reg and D_row immediately. There is no partial-result recovery.

Test Plan:
- Reset: hold reset=0 with random inputs toggling -> D_row=0 on every cycle. After release with A=0, C=0 -> D_row stays 0.
- Load then multiply:
  - edge 1: load_en=1, A=1, B_row lanes7..0={7,6,5,4,3,2,1,0}, C=0 -> D=0 (old b_reg=0).
  - edge 2: load_en=0, A=2, B_row={0,3,5,4,7,2,8,0} (must not load) -> D lanes7..0={14,12,10,8,6,4,2,0}.
- C add: with b_reg={7..0}, A=3, C lanes all 1, acc_en=0 -> D={22,19,16,13,10,7,4,1}.
- Accumulate: from D=0, b_reg={7..0}, A=1, acc_en=1 for 3 edges -> D={21,18,15,12,9,6,3,0}. Then A=0 with acc_en=1 -> D holds.
- Wrap: load B lanes all 8'hFF, then A=2, C=0 -> D lanes 8'hFE. Then C lanes 8'h03 -> D lanes 8'h01.
- Async reset mid-run: during the accumulate scenario, drop reset between clock edges -> D_row and b_reg read 0 before the next edge. After release, A=1, acc_en=0, C=0 -> D=0 (b_reg cleared).
